// File: rtl/change_dispenser.sv
// Coin payout engine: captures a change amount on finish and releases it one coin per
// clock, largest denomination first, keeping per-denomination tallies for the transaction.
module change_dispenser #(
  parameter int D3 = 50,
  parameter int D2 = 10,
  parameter int D1 = 5,
  parameter int D0 = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       finish,
  input  logic [5:0] change,
  output logic       busy,
  output logic       coin_valid,
  output logic [1:0] coin_type,
  output logic       done,
  output logic [2:0] cnt3,
  output logic [2:0] cnt2,
  output logic [2:0] cnt1,
  output logic [2:0] cnt0,
  output logic [3:0] coin_total
);

  typedef enum logic {
    IDLE = 1'b0,
    DISP = 1'b1
  } state_t;

  localparam logic [5:0] D3_V = 6'(D3);
  localparam logic [5:0] D2_V = 6'(D2);
  localparam logic [5:0] D1_V = 6'(D1);
  localparam logic [5:0] D0_V = 6'(D0);

  state_t     state_r;
  logic [5:0] remaining_r;
  logic [1:0] sel_type_s;
  logic [5:0] sel_val_s;
  logic       has_coin_s;

  // Greedy choice of the next coin from the amount still owed.
  always_comb begin
    sel_type_s = 2'd0;
    sel_val_s  = 6'd0;
    has_coin_s = 1'b0;
    if (remaining_r >= D3_V) begin
      sel_type_s = 2'd3;
      sel_val_s  = D3_V;
      has_coin_s = 1'b1;
    end else if (remaining_r >= D2_V) begin
      sel_type_s = 2'd2;
      sel_val_s  = D2_V;
      has_coin_s = 1'b1;
    end else if (remaining_r >= D1_V) begin
      sel_type_s = 2'd1;
      sel_val_s  = D1_V;
      has_coin_s = 1'b1;
    end else if (remaining_r != 6'd0) begin
      sel_type_s = 2'd0;
      sel_val_s  = D0_V;
      has_coin_s = 1'b1;
    end else begin
      has_coin_s = 1'b0;
    end
  end

  // Capture/dispense state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      remaining_r <= 6'd0;
      busy        <= 1'b0;
      coin_valid  <= 1'b0;
      coin_type   <= 2'd0;
      done        <= 1'b0;
      cnt3        <= 3'd0;
      cnt2        <= 3'd0;
      cnt1        <= 3'd0;
      cnt0        <= 3'd0;
      coin_total  <= 4'd0;
    end else begin
      coin_valid <= 1'b0;
      coin_type  <= 2'd0;
      done       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (finish) begin
            remaining_r <= change;
            cnt3        <= 3'd0;
            cnt2        <= 3'd0;
            cnt1        <= 3'd0;
            cnt0        <= 3'd0;
            coin_total  <= 4'd0;
            busy        <= 1'b1;
            state_r     <= DISP;
          end else begin
            state_r <= IDLE;
          end
        end
        DISP: begin
          // finish is deliberately not looked at here: requests while busy are dropped.
          if (has_coin_s) begin
            coin_valid  <= 1'b1;
            coin_type   <= sel_type_s;
            remaining_r <= remaining_r - sel_val_s;
            coin_total  <= coin_total + 4'd1;
            case (sel_type_s)
              2'd3:    cnt3 <= cnt3 + 3'd1;
              2'd2:    cnt2 <= cnt2 + 3'd1;
              2'd1:    cnt1 <= cnt1 + 3'd1;
              default: cnt0 <= cnt0 + 3'd1;
            endcase
          end else begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
